// File: rtl/serializer.sv
// Parallel-to-serial converter: sends the top N bits of a DATA_W word, one per clock, with a valid strobe.
// Define SERIALIZER_LSB_FIRST_EN to send data_i[0] first instead of data_i[DATA_W-1].
module serializer #(
  parameter int DATA_W = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic [$clog2(DATA_W)-1:0] data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  localparam int MOD_W = $clog2(DATA_W);
  localparam int CNT_W = MOD_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   shreg_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                ser_data_r;
  logic                ser_val_r;
  logic                busy_r;

  logic                mod_ok_s;
  logic                accept_s;
  logic [CNT_W-1:0]    n_s;
  logic                load_bit_s;
  logic [DATA_W-1:0]   load_word_s;
  logic                shift_bit_s;
  logic [DATA_W-1:0]   shift_word_s;

  // The shift register always holds the not-yet-sent bits aligned to the output end.
`ifdef SERIALIZER_LSB_FIRST_EN
  assign load_bit_s   = data_i[0];
  assign load_word_s  = {1'b0, data_i[DATA_W-1:1]};
  assign shift_bit_s  = shreg_r[0];
  assign shift_word_s = {1'b0, shreg_r[DATA_W-1:1]};
`else
  assign load_bit_s   = data_i[DATA_W-1];
  assign load_word_s  = {data_i[DATA_W-2:0], 1'b0};
  assign shift_bit_s  = shreg_r[DATA_W-1];
  assign shift_word_s = {shreg_r[DATA_W-2:0], 1'b0};
`endif

  assign mod_ok_s = (data_mod_i != MOD_W'(1)) && (data_mod_i != MOD_W'(2));
  assign accept_s = data_val_i && !busy_r && mod_ok_s;

  // Bit count: 0 selects the full word; codes beyond the word width saturate to it.
  always_comb begin
    n_s = CNT_W'(DATA_W);
    if ((data_mod_i == MOD_W'(0)) || ({1'b0, data_mod_i} >= CNT_W'(DATA_W))) begin
      n_s = CNT_W'(DATA_W);
    end else begin
      n_s = {1'b0, data_mod_i};
    end
  end

  // Control FSM with registered serial outputs; cnt_r counts bits left including the one on the wire.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r    <= ST_IDLE;
      shreg_r    <= '0;
      cnt_r      <= '0;
      ser_data_r <= 1'b0;
      ser_val_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r    <= ST_SHIFT;
            shreg_r    <= load_word_s;
            cnt_r      <= n_s;
            ser_data_r <= load_bit_s;
            ser_val_r  <= 1'b1;
            busy_r     <= (n_s > CNT_W'(1));
          end else begin
            ser_data_r <= 1'b0;
            ser_val_r  <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (cnt_r > CNT_W'(1)) begin
            shreg_r    <= shift_word_s;
            cnt_r      <= cnt_r - CNT_W'(1);
            ser_data_r <= shift_bit_s;
            ser_val_r  <= 1'b1;
            busy_r     <= (cnt_r > CNT_W'(2));
          end else if (accept_s) begin
            // Last bit on the wire and a new word arrives: reload without a gap.
            shreg_r    <= load_word_s;
            cnt_r      <= n_s;
            ser_data_r <= load_bit_s;
            ser_val_r  <= 1'b1;
            busy_r     <= (n_s > CNT_W'(1));
          end else begin
            state_r    <= ST_IDLE;
            shreg_r    <= '0;
            cnt_r      <= '0;
            ser_data_r <= 1'b0;
            ser_val_r  <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          shreg_r    <= '0;
          cnt_r      <= '0;
          ser_data_r <= 1'b0;
          ser_val_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign ser_data_o     = ser_data_r;
  assign ser_data_val_o = ser_val_r;
  assign busy_o         = busy_r;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: expected serial bits are queued when a word is offered and popped per valid cycle.
module tb_serializer;

  localparam int DATA_W = 16;
  localparam int MOD_W  = $clog2(DATA_W);

  logic              clk_i = 1'b0;
  logic              arst_n_i;
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   sb[$];

  serializer #(.DATA_W(DATA_W)) dut (
    .clk_i          (clk_i),
    .arst_n_i       (arst_n_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue the bits the specification says a word of this count must produce.
  task automatic push_word(input logic [DATA_W-1:0] d, input int mod);
    int n;
    n = (mod == 0) ? DATA_W : mod;
    for (int i = 0; i < n; i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
      sb.push_back(d[i]);
`else
      sb.push_back(d[DATA_W-1-i]);
`endif
    end
  endtask

  // One clock: sample #1 after the edge and check against the scoreboard.
  task automatic step(input string tag);
    logic exp_val;
    @(posedge clk_i);
    #1;
    exp_val = (sb.size() > 0);
    check({tag, "_val"}, ser_data_val_o, exp_val);
    if (exp_val) begin
      check({tag, "_busy"}, busy_o, (sb.size() > 1));
      check({tag, "_bit"}, ser_data_o, sb.pop_front());
    end else begin
      check({tag, "_idle_data"}, ser_data_o, 1'b0);
      check({tag, "_idle_busy"}, busy_o, 1'b0);
    end
  endtask

  task automatic send(input string tag, input logic [DATA_W-1:0] d, input int mod, input bit exp_acc);
    data_i     = d;
    data_mod_i = MOD_W'(mod);
    data_val_i = 1'b1;
    if (exp_acc) push_word(d, mod);
    step(tag);
    data_val_i = 1'b0;
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    arst_n_i   = 1'b0;
    data_i     = '0;
    data_mod_i = '0;
    data_val_i = 1'b0;
    #12;
    check("rst_data", ser_data_o, 1'b0);
    check("rst_val", ser_data_val_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    arst_n_i = 1'b1;
    steps("post_rst", 2);

    // Full 16-bit word; busy must drop on the 16th bit.
    send("t1", 16'hA5C3, 0, 1'b1);
    steps("t1", 15);
    steps("t1_end", 2);

    // Short word of 5 bits, then idle with data forced low.
    send("t2", 16'hF000, 5, 1'b1);
    steps("t2", 4);
    steps("t2_end", 2);

    // Minimum legal count.
    send("t2b", 16'h6001, 3, 1'b1);
    steps("t2b", 2);
    steps("t2b_end", 1);

    // Invalid counts are dropped.
    send("t3_m1", 16'hFFFF, 1, 1'b0);
    send("t3_m2", 16'hFFFF, 2, 1'b0);
    steps("t3", 2);

    // Back-to-back: second word offered on the last-bit cycle.
    send("t4a", 16'hFFFF, 0, 1'b1);
    steps("t4a", 15);
    send("t4b", 16'h0000, 4, 1'b1);
    steps("t4b", 3);
    steps("t4_end", 2);

    // Request while busy is ignored; original word completes.
    send("t5", 16'hC3A5, 0, 1'b1);
    steps("t5", 3);
    check("t5_busy_pre", busy_o, 1'b1);
    send("t5_ign", 16'h1234, 0, 1'b0);
    steps("t5", 11);
    steps("t5_end", 2);

    // Back-to-back with maximum non-zero count, LSB-side bits must be skipped.
    send("t4c", 16'h8421, 15, 1'b1);
    steps("t4c", 14);
    send("t4d", 16'h7E81, 7, 1'b1);
    steps("t4d", 6);
    steps("t4d_end", 1);

    // Async reset mid-word.
    send("t6", 16'hA5C3, 0, 1'b1);
    steps("t6", 7);
    #2;
    arst_n_i = 1'b0;
    #1;
    check("t6_rst_data", ser_data_o, 1'b0);
    check("t6_rst_val", ser_data_val_o, 1'b0);
    check("t6_rst_busy", busy_o, 1'b0);
    sb.delete();
    @(posedge clk_i);
    #1;
    check("t6_hold_val", ser_data_val_o, 1'b0);
    arst_n_i = 1'b1;
    steps("t6_idle", 3);
    send("t6_new", 16'h5A3C, 0, 1'b1);
    steps("t6_new", 15);
    steps("t6_end", 2);

    check("sb_drained", (sb.size() == 0), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
